// File: rtl/treasure_vote_ctrl_if.sv
// Handshake and frame-verdict bundle between the treasure vote sequencer,
// the per-frame classifier and the Arduino request/acknowledge pins.
interface treasure_vote_ctrl_if;
    logic       VGA_VSYNC_NEG;
    logic       START;
    logic       FRAME_VALID;
    logic [2:0] FRAME_SHAPE;
    logic       FRAME_RED;
    logic       ACK;
    logic       PROC_CLEAR;
    logic       BUSY;
    logic       DONE;
    logic [3:0] RESULT;

    // Camera/Arduino side: drives requests and verdicts, observes the result.
    modport master (
        output VGA_VSYNC_NEG, START, FRAME_VALID, FRAME_SHAPE, FRAME_RED, ACK,
        input  PROC_CLEAR, BUSY, DONE, RESULT
    );

    // Sequencer side.
    modport slave (
        input  VGA_VSYNC_NEG, START, FRAME_VALID, FRAME_SHAPE, FRAME_RED, ACK,
        output PROC_CLEAR, BUSY, DONE, RESULT
    );
endinterface

// File: rtl/treasure_vote_ctrl.sv
// Frame-level sequencer around the shape/colour classifier: aligns to a frame
// boundary, clears the classifier, collects NUM_FRAMES verdicts, majority-votes
// them and reports one registered treasure code over a DONE/ACK handshake.
//
// state  | meaning
// IDLE   | waiting for START, RESULT holds the previous answer
// SYNC   | waiting for a frame boundary before clearing the classifier
// ACCUM  | counting verdicts and frame boundaries
// DECIDE | one cycle: evaluate the votes
// REPORT | DONE high until ACK is sampled
module treasure_vote_ctrl #(
    parameter int NUM_FRAMES      = 16,
    parameter int MIN_VOTES       = 4,
    parameter int WATCHDOG_FRAMES = 32,
    parameter int VOTE_W          = 8
) (
    input logic                CLK,
    input logic                RESET,
    treasure_vote_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_ACCUM  = 3'd2,
        S_DECIDE = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    localparam logic [VOTE_W-1:0] NUM_FRAMES_C = VOTE_W'(NUM_FRAMES);
    localparam logic [VOTE_W-1:0] MIN_VOTES_C  = VOTE_W'(MIN_VOTES);
    localparam logic [VOTE_W-1:0] WATCHDOG_C   = VOTE_W'(WATCHDOG_FRAMES);

    state_t            state_q, state_d;
    logic              vsync_q;
    logic              proc_clear_q, proc_clear_d;
    logic [VOTE_W-1:0] valid_cnt_q, valid_cnt_d;
    logic [VOTE_W-1:0] fb_cnt_q, fb_cnt_d;
    logic [VOTE_W-1:0] tri_votes_q, tri_votes_d;
    logic [VOTE_W-1:0] sq_votes_q, sq_votes_d;
    logic [VOTE_W-1:0] dia_votes_q, dia_votes_d;
    logic [VOTE_W-1:0] red_votes_q, red_votes_d;
    logic [VOTE_W-1:0] blue_votes_q, blue_votes_d;
    logic [3:0]        result_q, result_d;

    logic              fb;
    logic [2:0]        winner;
    logic [3:0]        decision;

    // Counters stop at all-ones instead of wrapping so a long run cannot
    // flip a clear majority into a minority.
    function automatic logic [VOTE_W-1:0] sat_inc(input logic [VOTE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Frame boundary: VSYNC_NEG falling, seen against last cycle's sample.
    assign fb = vsync_q & ~bus.VGA_VSYNC_NEG;

    // Majority decision from the settled vote counters; only read in DECIDE.
    always_comb begin
        winner = 3'b000;
        if ((tri_votes_q > sq_votes_q) && (tri_votes_q > dia_votes_q) &&
            (tri_votes_q >= MIN_VOTES_C))
            winner = 3'b100;
        else if ((sq_votes_q > tri_votes_q) && (sq_votes_q > dia_votes_q) &&
                 (sq_votes_q >= MIN_VOTES_C))
            winner = 3'b010;
        else if ((dia_votes_q > tri_votes_q) && (dia_votes_q > sq_votes_q) &&
                 (dia_votes_q >= MIN_VOTES_C))
            winner = 3'b001;

        if ((winner != 3'b000) && (red_votes_q != blue_votes_q))
            decision = {(red_votes_q > blue_votes_q), winner};
        else
            decision = 4'b0000;
    end

    // Next-state, counter updates and the clear pulse.
    always_comb begin
        state_d      = state_q;
        proc_clear_d = 1'b0;
        valid_cnt_d  = valid_cnt_q;
        fb_cnt_d     = fb_cnt_q;
        tri_votes_d  = tri_votes_q;
        sq_votes_d   = sq_votes_q;
        dia_votes_d  = dia_votes_q;
        red_votes_d  = red_votes_q;
        blue_votes_d = blue_votes_q;
        result_d     = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.START)
                    state_d = S_SYNC;
            end

            S_SYNC: begin
                if (fb) begin
                    proc_clear_d = 1'b1;
                    valid_cnt_d  = '0;
                    fb_cnt_d     = '0;
                    tri_votes_d  = '0;
                    sq_votes_d   = '0;
                    dia_votes_d  = '0;
                    red_votes_d  = '0;
                    blue_votes_d = '0;
                    state_d      = S_ACCUM;
                end
            end

            S_ACCUM: begin
                if (bus.FRAME_VALID) begin
                    valid_cnt_d = sat_inc(valid_cnt_q);
                    // Malformed verdicts (zero or several shape bits) only
                    // advance valid_cnt; they carry no shape or colour vote.
                    case (bus.FRAME_SHAPE)
                        3'b100: tri_votes_d = sat_inc(tri_votes_q);
                        3'b010: sq_votes_d  = sat_inc(sq_votes_q);
                        3'b001: dia_votes_d = sat_inc(dia_votes_q);
                        default: ;
                    endcase
                    if (bus.FRAME_SHAPE == 3'b100 || bus.FRAME_SHAPE == 3'b010 ||
                        bus.FRAME_SHAPE == 3'b001) begin
                        if (bus.FRAME_RED)
                            red_votes_d = sat_inc(red_votes_q);
                        else
                            blue_votes_d = sat_inc(blue_votes_q);
                    end
                end
                if (fb)
                    fb_cnt_d = sat_inc(fb_cnt_q);
                // Compare the updated counts so a verdict on the exit cycle
                // is included in the vote.
                if ((valid_cnt_d == NUM_FRAMES_C) || (fb_cnt_d == WATCHDOG_C))
                    state_d = S_DECIDE;
            end

            S_DECIDE: begin
                result_d = decision;
                state_d  = S_REPORT;
            end

            S_REPORT: begin
                if (bus.ACK)
                    state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and result register with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            proc_clear_q <= 1'b0;
            valid_cnt_q  <= '0;
            fb_cnt_q     <= '0;
            tri_votes_q  <= '0;
            sq_votes_q   <= '0;
            dia_votes_q  <= '0;
            red_votes_q  <= '0;
            blue_votes_q <= '0;
            result_q     <= 4'b0000;
        end else begin
            state_q      <= state_d;
            vsync_q      <= bus.VGA_VSYNC_NEG;
            proc_clear_q <= proc_clear_d;
            valid_cnt_q  <= valid_cnt_d;
            fb_cnt_q     <= fb_cnt_d;
            tri_votes_q  <= tri_votes_d;
            sq_votes_q   <= sq_votes_d;
            dia_votes_q  <= dia_votes_d;
            red_votes_q  <= red_votes_d;
            blue_votes_q <= blue_votes_d;
            result_q     <= result_d;
        end
    end

    assign bus.PROC_CLEAR = proc_clear_q;
    assign bus.BUSY       = (state_q != S_IDLE);
    assign bus.DONE       = (state_q == S_REPORT);
    assign bus.RESULT     = result_q;

endmodule

// File: tb/tb_treasure_vote_ctrl.sv
// Directed bench for treasure_vote_ctrl with NUM_FRAMES=4, MIN_VOTES=2,
// WATCHDOG_FRAMES=8.
module tb_treasure_vote_ctrl;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   errors = 0;

    treasure_vote_ctrl_if bus();

    treasure_vote_ctrl #(
        .NUM_FRAMES(4), .MIN_VOTES(2), .WATCHDOG_FRAMES(8), .VOTE_W(8)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    always #20 CLK = ~CLK;

    localparam logic [2:0] TRI = 3'b100, SQR = 3'b010, DIA = 3'b001;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One frame boundary: VSYNC_NEG low for one cycle, then high again.
    task automatic do_fb();
        bus.VGA_VSYNC_NEG = 1'b0;
        tick();
        bus.VGA_VSYNC_NEG = 1'b1;
        tick();
    endtask

    task automatic verdict(input logic [2:0] shape, input logic red);
        bus.FRAME_VALID = 1'b1;
        bus.FRAME_SHAPE = shape;
        bus.FRAME_RED   = red;
        tick();
        bus.FRAME_VALID = 1'b0;
        bus.FRAME_SHAPE = 3'b000;
        bus.FRAME_RED   = 1'b0;
    endtask

    // From IDLE: request, align to a boundary and check the clear pulse.
    task automatic start_sync(input logic keep_start);
        bus.START = 1'b1;
        tick();
        if (!keep_start) bus.START = 1'b0;
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL sync_busy: got %b want 1", bus.BUSY); end
        checks++; if (bus.PROC_CLEAR !== 1'b0) begin errors++; $display("FAIL clear_early: got %b want 0", bus.PROC_CLEAR); end
        bus.VGA_VSYNC_NEG = 1'b0;
        tick();
        checks++; if (bus.PROC_CLEAR !== 1'b1) begin errors++; $display("FAIL clear_pulse: got %b want 1", bus.PROC_CLEAR); end
        bus.VGA_VSYNC_NEG = 1'b1;
        tick();
        checks++; if (bus.PROC_CLEAR !== 1'b0) begin errors++; $display("FAIL clear_width: got %b want 0", bus.PROC_CLEAR); end
    endtask

    // Four verdicts, then the DECIDE cycle and first REPORT cycle.
    task automatic run4(input string name, input logic [11:0] shapes,
                        input logic [3:0] reds, input logic [3:0] exp_result);
        for (int i = 0; i < 4; i++) begin
            verdict(shapes[3*i +: 3], reds[i]);
            if (i < 3) begin
                checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL %s_early_done%0d: got %b want 0", name, i, bus.DONE); end
            end
        end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL %s_decide_done: got %b want 0", name, bus.DONE); end
        tick();
        checks++; if (bus.DONE !== 1'b1) begin errors++; $display("FAIL %s_done_rise: got %b want 1", name, bus.DONE); end
        checks++; if (bus.RESULT !== exp_result) begin errors++; $display("FAIL %s_result: got %b want %b", name, bus.RESULT, exp_result); end
    endtask

    task automatic ack_cycle(input string name);
        tick();
        checks++; if (bus.DONE !== 1'b1) begin errors++; $display("FAIL %s_done_hold: got %b want 1", name, bus.DONE); end
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
        checks++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL %s_ack: got done=%b busy=%b want 0 0", name, bus.DONE, bus.BUSY); end
    endtask

    task automatic test_reset();
        bus.VGA_VSYNC_NEG = 1'b1; bus.START = 1'b0; bus.FRAME_VALID = 1'b0;
        bus.FRAME_SHAPE = 3'b000; bus.FRAME_RED = 1'b0; bus.ACK = 1'b0;
        RESET = 1'b1;
        tick(); tick();
        checks++; if ({bus.PROC_CLEAR, bus.BUSY, bus.DONE, bus.RESULT} !== 7'b0)
            begin errors++; $display("FAIL reset_outputs: got %b want 0000000", {bus.PROC_CLEAR, bus.BUSY, bus.DONE, bus.RESULT}); end
        RESET = 1'b0;
        tick(); tick();
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.BUSY); end
    endtask

    task automatic test_square_red();
        start_sync(1'b0);
        run4("sq_red", {SQR, SQR, SQR, SQR}, 4'b1111, 4'b1010);
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL sq_red_ack: got %b want 0", bus.DONE); end
        checks++; if (bus.RESULT !== 4'b1010) begin errors++; $display("FAIL idle_keeps_result: got %b want 1010", bus.RESULT); end
    endtask

    task automatic test_blue_triangle();
        start_sync(1'b0);
        // order in time: tri/blue, tri/blue, diam/blue, tri/red
        run4("tri_blue", {TRI, DIA, TRI, TRI}, 4'b1000, 4'b0100);
        ack_cycle("tri_blue");
    endtask

    task automatic test_shape_tie();
        start_sync(1'b0);
        run4("tie", {DIA, DIA, SQR, SQR}, 4'b1111, 4'b0000);
        ack_cycle("tie");
    endtask

    task automatic test_watchdog();
        start_sync(1'b0);
        verdict(DIA, 1'b1);
        verdict(DIA, 1'b1);
        for (int i = 0; i < 7; i++) do_fb();
        checks++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b1) begin errors++; $display("FAIL wd_early: got done=%b busy=%b want 0 1", bus.DONE, bus.BUSY); end
        bus.VGA_VSYNC_NEG = 1'b0;
        tick();
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL wd_decide_done: got %b want 0", bus.DONE); end
        bus.VGA_VSYNC_NEG = 1'b1;
        tick();
        checks++; if (bus.DONE !== 1'b1) begin errors++; $display("FAIL wd_done: got %b want 1", bus.DONE); end
        checks++; if (bus.RESULT !== 4'b1001) begin errors++; $display("FAIL wd_result: got %b want 1001", bus.RESULT); end
        ack_cycle("wd");
    endtask

    task automatic test_back_to_back();
        start_sync(1'b1);
        run4("b2b_a", {SQR, SQR, SQR, SQR}, 4'b0000, 4'b0010);
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", bus.BUSY); end
        tick();
        bus.START = 1'b0;
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b want 1", bus.BUSY); end
        bus.VGA_VSYNC_NEG = 1'b0;
        tick();
        checks++; if (bus.PROC_CLEAR !== 1'b1) begin errors++; $display("FAIL b2b_clear: got %b want 1", bus.PROC_CLEAR); end
        bus.VGA_VSYNC_NEG = 1'b1;
        tick();
        run4("b2b_b", {TRI, TRI, TRI, DIA}, 4'b1110, 4'b1100);
        ack_cycle("b2b_b");
    endtask

    task automatic test_invalid_shape_ack_early();
        start_sync(1'b0);
        verdict(3'b011, 1'b1);
        verdict(DIA, 1'b0);
        verdict(DIA, 1'b0);
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL inv_early: got %b want 0", bus.DONE); end
        verdict(DIA, 1'b0);
        bus.ACK = 1'b1;
        tick();
        checks++; if (bus.DONE !== 1'b1) begin errors++; $display("FAIL inv_done: got %b want 1", bus.DONE); end
        checks++; if (bus.RESULT !== 4'b0001) begin errors++; $display("FAIL inv_result: got %b want 0001", bus.RESULT); end
        tick();
        bus.ACK = 1'b0;
        checks++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL inv_one_cycle: got done=%b busy=%b want 0 0", bus.DONE, bus.BUSY); end
    endtask

    task automatic test_reset_mid_accum();
        start_sync(1'b0);
        verdict(SQR, 1'b1);
        verdict(SQR, 1'b1);
        verdict(SQR, 1'b1);
        checks++; if (bus.RESULT !== 4'b0001) begin errors++; $display("FAIL pre_reset_result: got %b want 0001", bus.RESULT); end
        #5;
        RESET = 1'b1;
        #2;
        checks++; if ({bus.BUSY, bus.DONE, bus.RESULT} !== 6'b0) begin errors++; $display("FAIL async_reset: got %b want 000000", {bus.BUSY, bus.DONE, bus.RESULT}); end
        tick();
        RESET = 1'b0;
        tick();
        start_sync(1'b0);
        verdict(SQR, 1'b1);
        verdict(SQR, 1'b1);
        verdict(SQR, 1'b1);
        tick(); tick();
        checks++; if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b1) begin errors++; $display("FAIL fresh_count: got done=%b busy=%b want 0 1", bus.DONE, bus.BUSY); end
        verdict(SQR, 1'b1);
        tick();
        checks++; if (bus.DONE !== 1'b1 || bus.RESULT !== 4'b1010) begin errors++; $display("FAIL post_reset_result: got done=%b result=%b want 1 1010", bus.DONE, bus.RESULT); end
        ack_cycle("post_reset");
    endtask

    initial begin
        test_reset();
        test_square_red();
        test_blue_triangle();
        test_shape_tie();
        test_watchdog();
        test_back_to_back();
        test_invalid_shape_ack_early();
        test_reset_mid_accum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish before 2ms");
        $fatal(1);
    end
endmodule
